tx_data_buffer: RTL

TX_DATA_BUFFER -- requirements
Module: tx_data_buffer

---
 rtl/usb_pkg.sv | 30 +++
 rtl/tx_buffer_mem.sv | 34 +++
 rtl/tx_data_buffer.sv | 119 +++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// Shared USB device package.
// Holds the transmit-buffer geometry used by tx_data_buffer and tx_buffer_mem.
// Also holds the packet-ID encodings used by the transmitter.
package usb_pkg;

  // Transmit buffer geometry: 64 byte entries, 6-bit wrapping pointers, and a
  // 7-bit occupancy count so that the full state (64) can be represented.
  localparam int BUFFER_DEPTH = 64;
  localparam int PTR_W        = 6;
  localparam int OCC_W        = 7;

  // USB packet identifiers (low nibble of the PID byte).
  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } usb_pid_e;

  // The PID byte on the wire carries the PID and its one's complement check.
  function automatic logic [7:0] pid_byte(input usb_pid_e pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/tx_buffer_mem.sv
// Register-file storage for the transmit buffer.
// It has one synchronous write port and one asynchronous read port.
// The storage is deliberately not reset; entries are don't-care until written.
// Ports:
//   clk_i    - clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational)
module tx_buffer_mem #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tx_data_buffer.sv
// Transmit data buffer: a 64-byte first-word-fall-through FIFO.
// The host side writes into it and the USB transmitter drains it.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   store_tx_data/tx_data - push strobe and byte
//   clear                 - flush all contents and error flags
//   get_tx_packet_data    - pop strobe
//   tx_packet_data        - head byte (00 when empty)
//   buffer_occupancy      - stored byte count 0..64
//   buffer_full/empty     - decoded from occupancy
//   overflow_err          - sticky flag: a push was attempted while full
//   underflow_err         - sticky flag: a pop was attempted while empty
module tx_data_buffer
  import usb_pkg::*;
#(
  parameter int DEPTH  = BUFFER_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              clear,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              buffer_full,
  output logic              buffer_empty,
  output logic              overflow_err,
  output logic              underflow_err
);

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full;
  logic              empty;
  logic              pop_ok;
  logic              push_ok;
  logic              mem_we;
  logic [DATA_W-1:0] head;

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

  // A push when full is still accepted if a pop frees the head slot on the
  // same edge. When full, the write slot equals the head slot being popped,
  // so the new byte lands there only after the old head has been read out.
  assign pop_ok  = get_tx_packet_data && !empty;
  assign push_ok = store_tx_data && (!full || pop_ok);
  assign mem_we  = push_ok && !clear && !rst;

  tx_buffer_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (tx_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
      // A full-buffer push paired with a pop is not an overflow.
      if (store_tx_data && full && !get_tx_packet_data) ovf_d = 1'b1;
      if (get_tx_packet_data && empty)                  unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Stale storage contents must never leak out while empty.
  assign tx_packet_data   = empty ? '0 : head;
  assign buffer_occupancy = occ_q;
  assign buffer_full      = full;
  assign buffer_empty     = empty;
  assign overflow_err     = ovf_q;
  assign underflow_err    = unf_q;

endmodule
